// File: rtl/sq_diff_scheduler_pkg.sv
// Shared constants for the (A+B)*(A-B) scheduler: default widths and FSM state encodings.
package sq_diff_pkg;

    localparam int SQD_WIDTH = 16;
    localparam int SQD_CNTW  = 4;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t FIN  = 2'd2;

endpackage

// File: rtl/sq_diff_scheduler_if.sv
// Requester-side bus of the scheduler: request/operand inputs, grant/done/result outputs.
interface sq_diff_scheduler_if #(
    parameter int WIDTH = 16
);
    logic [1:0]         REQ;
    logic [WIDTH-1:0]   A0;
    logic [WIDTH-1:0]   B0;
    logic [WIDTH-1:0]   A1;
    logic [WIDTH-1:0]   B1;
    logic [1:0]         GNT;
    logic [1:0]         DONE;
    logic [2*WIDTH-1:0] OUT;
    logic               OUT_ID;
    logic               BUSY;

    modport master (
        output REQ, A0, B0, A1, B1,
        input  GNT, DONE, OUT, OUT_ID, BUSY
    );

    modport slave (
        input  REQ, A0, B0, A1, B1,
        output GNT, DONE, OUT, OUT_ID, BUSY
    );
endinterface

// File: rtl/sq_diff_scheduler_shift_add_core.sv
// Iterative shift-add engine: loads X=A+B and Y=A-B, then adds Y<<cnt for each set bit of X, one bit per step.
module shift_add_core #(
    parameter int WIDTH = 16,
    parameter int CNTW  = 4
) (
    input  logic               clk,
    input  logic               srst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] acc_next,
    output logic               last
);
    logic [WIDTH-1:0]   x_reg;
    logic [WIDTH-1:0]   y_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [CNTW-1:0]    cnt_reg;
    logic [2*WIDTH-1:0] y_wide;
    logic [2*WIDTH-1:0] addend;

    assign y_wide   = {{WIDTH{1'b0}}, y_reg};
    assign addend   = x_reg[cnt_reg] ? (y_wide << cnt_reg) : '0;
    // acc_next already includes the current bit, so the owner can capture it on the last step
    assign acc_next = acc_reg + addend;
    assign last     = (cnt_reg == CNTW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (srst) begin
            x_reg   <= '0;
            y_reg   <= '0;
            acc_reg <= '0;
            cnt_reg <= '0;
        end else if (load) begin
            x_reg   <= a + b;
            y_reg   <= a - b;
            acc_reg <= '0;
            cnt_reg <= '0;
        end else if (step) begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_reg + CNTW'(1);
        end
    end
endmodule

// File: rtl/sq_diff_scheduler.sv
// Round-robin scheduler sharing one shift-add engine between two requesters; GNT/DONE are one-cycle pulses.
module sq_diff_scheduler
    import sq_diff_pkg::*;
#(
    parameter int WIDTH = SQD_WIDTH,
    parameter int CNTW  = SQD_CNTW
) (
    input  logic                CLK,
    input  logic                RST,
    sq_diff_scheduler_if.slave  bus
);
    state_t             state_reg;
    logic               pri_reg;
    logic               sel_reg;
    logic               gnt_pulse_reg;
    logic               done_pulse_reg;
    logic               out_id_reg;
    logic [2*WIDTH-1:0] out_reg;

    logic               any_req;
    logic               sel_next;
    logic               core_load;
    logic               core_step;
    logic               core_last;
    logic [WIDTH-1:0]   a_sel;
    logic [WIDTH-1:0]   b_sel;
    logic [2*WIDTH-1:0] core_acc_next;

    // Single request wins outright; a tie goes to the requester named by PRI.
    assign any_req   = |bus.REQ;
    assign sel_next  = (bus.REQ == 2'b11) ? pri_reg : bus.REQ[1];
    assign a_sel     = sel_next ? bus.A1 : bus.A0;
    assign b_sel     = sel_next ? bus.B1 : bus.B0;
    assign core_load = (state_reg == IDLE) && any_req;
    assign core_step = (state_reg == RUN);

    shift_add_core #(
        .WIDTH (WIDTH),
        .CNTW  (CNTW)
    ) u_core (
        .clk      (CLK),
        .srst     (RST),
        .load     (core_load),
        .step     (core_step),
        .a        (a_sel),
        .b        (b_sel),
        .acc_next (core_acc_next),
        .last     (core_last)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg      <= IDLE;
            pri_reg        <= 1'b0;
            sel_reg        <= 1'b0;
            gnt_pulse_reg  <= 1'b0;
            done_pulse_reg <= 1'b0;
            out_id_reg     <= 1'b0;
            out_reg        <= '0;
        end else begin
            gnt_pulse_reg  <= 1'b0;
            done_pulse_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        sel_reg       <= sel_next;
                        pri_reg       <= ~sel_next;
                        gnt_pulse_reg <= 1'b1;
                        state_reg     <= RUN;
                    end
                end
                RUN: begin
                    if (core_last) begin
                        out_reg        <= core_acc_next;
                        out_id_reg     <= sel_reg;
                        done_pulse_reg <= 1'b1;
                        state_reg      <= FIN;
                    end
                end
                FIN: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Pulses are decoded from a flag plus an owner index, so at most one bit can ever be set.
    for (genvar gi = 0; gi < 2; gi++) begin : g_pulse
        assign bus.GNT[gi]  = gnt_pulse_reg  && (sel_reg    == 1'(gi));
        assign bus.DONE[gi] = done_pulse_reg && (out_id_reg == 1'(gi));
    end

    assign bus.OUT    = out_reg;
    assign bus.OUT_ID = out_id_reg;
    assign bus.BUSY   = (state_reg == RUN) || (state_reg == FIN);
endmodule

// File: tb/tb_sq_diff_scheduler.sv
// Directed bench for sq_diff_scheduler: stimulus pushes expected results, a negedge monitor checks each DONE.
module tb_sq_diff_scheduler;
    localparam int W = 16;

    typedef struct packed {
        logic        id;
        logic [31:0] out;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    sq_diff_scheduler_if #(.WIDTH(W)) bus ();

    sq_diff_scheduler #(
        .WIDTH (W),
        .CNTW  (4)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every DONE pulse pops the oldest expectation and compares result, owner and pulse bit.
    always @(negedge clk) begin
        if (!rst) begin
            if (($countones(bus.GNT) > 1) || ($countones(bus.DONE) > 1) || ((bus.GNT & bus.DONE) != 2'b00)) begin
                n_errors++;
                $display("FAIL pulse_onehot: GNT=%b DONE=%b at %0t", bus.GNT, bus.DONE, $time);
            end
            if (bus.DONE != 2'b00) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_done: DONE=%b OUT=%0d expected no completion", bus.DONE, bus.OUT);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (bus.OUT !== e.out || bus.OUT_ID !== e.id || bus.DONE !== (e.id ? 2'b10 : 2'b01)) begin
                        n_errors++;
                        $display("FAIL done_result: got id=%0d out=%0d done=%b expected id=%0d out=%0d",
                                 bus.OUT_ID, bus.OUT, bus.DONE, e.id, e.out);
                    end else begin
                        $display("done id=%0d out=%0d ok", bus.OUT_ID, bus.OUT);
                    end
                end
            end
        end
    end

    // Single request from idle: grant next cycle, DONE 16 cycles after the grant, idle the cycle after.
    task automatic do_op(input logic id, input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp_out);
        int k;
        if (id) begin
            bus.A1 = a;
            bus.B1 = b;
        end else begin
            bus.A0 = a;
            bus.B0 = b;
        end
        bus.REQ[id] = 1'b1;
        sb.push_back('{id, exp_out});
        $display("request id=%0d a=%0d b=%0d expect=%0d", id, a, b, exp_out);
        k = 0;
        do begin
            tick();
            k++;
        end while (bus.GNT == 2'b00 && k < 40);
        check("gnt_latency", k, 1);
        check("gnt_value", bus.GNT, id ? 2 : 1);
        check("busy_in_run", bus.BUSY, 1);
        bus.REQ[id] = 1'b0;
        do begin
            tick();
            k++;
        end while (bus.DONE == 2'b00 && k < 60);
        check("done_cycle", k, 17);
        check("busy_in_fin", bus.BUSY, 1);
        tick();
        check("idle_busy", bus.BUSY, 0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.REQ = 2'b00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g1;
        int gcount;
        bus.REQ = 2'b00;
        bus.A0 = '0;
        bus.B0 = '0;
        bus.A1 = '0;
        bus.B1 = '0;

        apply_reset();
        check("reset_gnt", bus.GNT, 0);
        check("reset_done", bus.DONE, 0);
        check("reset_out", bus.OUT, 0);
        check("reset_out_id", bus.OUT_ID, 0);
        check("reset_busy", bus.BUSY, 0);

        do_op(1'b0, 16'd5, 16'd4, 32'd9);
        do_op(1'b1, 16'd445, 16'd100, 32'd188025);
        do_op(1'b0, 16'd3, 16'd5, 32'd524272);
        do_op(1'b0, 16'd65535, 16'd65535, 32'd0);

        // Late request from requester 1 while requester 0 runs; requester 0 operands change after its grant.
        bus.A0 = 16'd7;
        bus.B0 = 16'd2;
        bus.REQ = 2'b01;
        sb.push_back('{1'b0, 32'd45});
        sb.push_back('{1'b1, 32'd91});
        g1 = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (c == 1) begin
                check("t5_gnt0", bus.GNT, 1);
                bus.REQ[0] = 1'b0;
            end
            if (c == 3) begin
                bus.A0 = 16'd1000;
                bus.B0 = 16'd1;
            end
            if (c == 5) begin
                bus.A1 = 16'd10;
                bus.B1 = 16'd3;
                bus.REQ[1] = 1'b1;
            end
            if (c > 1 && bus.GNT != 2'b00 && g1 == 0) begin
                g1 = c;
                check("t5_gnt1_value", bus.GNT, 2);
                bus.REQ[1] = 1'b0;
            end
            if (c == 17) check("t5_done0_pulse", bus.DONE, 1);
        end
        check("t5_gnt1_cycle", g1, 19);

        // Both requests held from reset: grants alternate every 18 cycles.
        apply_reset();
        bus.A0 = 16'd5;
        bus.B0 = 16'd4;
        bus.A1 = 16'd445;
        bus.B1 = 16'd100;
        bus.REQ = 2'b11;
        sb.push_back('{1'b0, 32'd9});
        sb.push_back('{1'b1, 32'd188025});
        sb.push_back('{1'b0, 32'd9});
        sb.push_back('{1'b1, 32'd188025});
        gcount = 0;
        for (int c = 1; c <= 73; c++) begin
            tick();
            if (c == 1 || c == 19 || c == 37 || c == 55) begin
                check("t4_gnt_alternate", bus.GNT, (c == 1 || c == 37) ? 1 : 2);
                $display("grant cycle=%0d GNT=%b", c, bus.GNT);
                gcount++;
                if (c == 55) bus.REQ = 2'b00;
            end else if (bus.GNT != 2'b00) begin
                check("t4_gnt_spurious", bus.GNT, 0);
            end
        end
        check("t4_grant_count", gcount, 4);

        // Reset in the middle of an operation aborts it; PRI returns to 0.
        bus.A0 = 16'd3;
        bus.B0 = 16'd5;
        bus.REQ = 2'b01;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 1) begin
                check("t6_gnt0", bus.GNT, 1);
                bus.REQ = 2'b00;
            end
        end
        rst = 1'b1;
        tick();
        check("t6_out_cleared", bus.OUT, 0);
        check("t6_busy_cleared", bus.BUSY, 0);
        check("t6_out_id_cleared", bus.OUT_ID, 0);
        rst = 1'b0;
        repeat (20) tick();

        bus.A0 = 16'd3;
        bus.B0 = 16'd5;
        bus.A1 = 16'd65535;
        bus.B1 = 16'd65535;
        bus.REQ = 2'b11;
        sb.push_back('{1'b0, 32'd524272});
        sb.push_back('{1'b1, 32'd0});
        g1 = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (c == 1) begin
                check("t6_first_gnt", bus.GNT, 1);
                bus.REQ[0] = 1'b0;
            end
            if (c > 1 && bus.GNT != 2'b00 && g1 == 0) begin
                g1 = c;
                check("t6_second_gnt", bus.GNT, 2);
                bus.REQ[1] = 1'b0;
            end
        end
        check("t6_second_gnt_cycle", g1, 19);

        repeat (3) tick();
        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
